// File: rtl/lsu_dmem_master_if.sv
// rtl/lsu_dmem_master_if.sv - data memory bus between the load/store unit and dmem
interface lsu_dmem_master_if;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wstrb;
   logic        mem_rsp_valid;
   logic [63:0] mem_rdata;

   modport master (
      output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_req_ready, mem_rsp_valid, mem_rdata
   );

   modport slave (
      input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_req_ready, mem_rsp_valid, mem_rdata
   );
endinterface

// File: rtl/lsu_dmem_master.sv
// rtl/lsu_dmem_master.sv - RV64I load/store initiator for the 64-bit data memory
module lsu_dmem_master #(
   parameter int DMEM_DEPTH = 1024,
   parameter int XLEN       = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err,
   lsu_dmem_master_if.master mem
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } state_t;

   state_t          state;
   logic            we_q;
   logic [1:0]      size_q;
   logic            unsigned_q;
   logic [2:0]      off_q;

   logic [XLEN-1:0] size_mask;
   logic [7:0]      strb_base;
   logic [XLEN-1:0] wdata_lane;
   logic [7:0]      wstrb_lane;
   logic            misaligned;
   logic            out_of_range;
   logic [XLEN-1:0] load_raw;
   logic [XLEN-1:0] load_ext;

   // Request-side decode, evaluated on the live core inputs at accept time.
   always_comb begin
      size_mask  = '1;
      strb_base  = 8'hFF;
      misaligned = 1'b0;
      case (req_size)
         2'b00: begin
            size_mask = 64'h0000_0000_0000_00FF;
            strb_base = 8'h01;
         end
         2'b01: begin
            size_mask  = 64'h0000_0000_0000_FFFF;
            strb_base  = 8'h03;
            misaligned = req_addr[0];
         end
         2'b10: begin
            size_mask  = 64'h0000_0000_FFFF_FFFF;
            strb_base  = 8'h0F;
            misaligned = |req_addr[1:0];
         end
         default: begin
            size_mask  = '1;
            strb_base  = 8'hFF;
            misaligned = |req_addr[2:0];
         end
      endcase
      wdata_lane   = (req_wdata & size_mask) << {req_addr[2:0], 3'b000};
      wstrb_lane   = strb_base << req_addr[2:0];
      out_of_range = (req_addr >> 3) >= 64'(DMEM_DEPTH);
   end

   // Response-side alignment uses the captured lane offset and size.
   always_comb begin
      load_raw = mem.mem_rdata >> {off_q, 3'b000};
      case (size_q)
         2'b00:   load_ext = {{56{~unsigned_q & load_raw[7]}},  load_raw[7:0]};
         2'b01:   load_ext = {{48{~unsigned_q & load_raw[15]}}, load_raw[15:0]};
         2'b10:   load_ext = {{32{~unsigned_q & load_raw[31]}}, load_raw[31:0]};
         default: load_ext = load_raw;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= S_IDLE;
         req_ready         <= 1'b1;
         rsp_valid         <= 1'b0;
         rsp_rdata         <= '0;
         rsp_err           <= 1'b0;
         mem.mem_req_valid <= 1'b0;
         mem.mem_we        <= 1'b0;
         mem.mem_addr      <= '0;
         mem.mem_wdata     <= '0;
         mem.mem_wstrb     <= '0;
         we_q              <= 1'b0;
         size_q            <= 2'b00;
         unsigned_q        <= 1'b0;
         off_q             <= 3'b000;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  req_ready  <= 1'b0;
                  we_q       <= req_we;
                  size_q     <= req_size;
                  unsigned_q <= req_unsigned;
                  off_q      <= req_addr[2:0];
                  if (misaligned || out_of_range) begin
                     state     <= S_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     state             <= S_REQ;
                     mem.mem_req_valid <= 1'b1;
                     mem.mem_we        <= req_we;
                     mem.mem_addr      <= {req_addr[XLEN-1:3], 3'b000};
                     mem.mem_wdata     <= req_we ? wdata_lane : '0;
                     mem.mem_wstrb     <= req_we ? wstrb_lane : 8'h00;
                  end
               end
            end
            S_REQ: begin
               if (mem.mem_req_ready) begin
                  mem.mem_req_valid <= 1'b0;
                  state             <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem.mem_rsp_valid) begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= we_q ? '0 : load_ext;
               end
            end
            S_RESP: begin
               state     <= S_IDLE;
               rsp_valid <= 1'b0;
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
               req_ready <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb/tb_lsu_dmem_master.sv - randomized self-checking bench for lsu_dmem_master
module tb_lsu_dmem_master;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        rsp_err;

   lsu_dmem_master_if bus();

   lsu_dmem_master #(.DMEM_DEPTH(DEPTH), .XLEN(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem          (bus.master)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0]  dmem_bytes [DEPTH*8];
   logic [63:0] last_rdata;
   logic [63:0] last_addr;
   logic [63:0] last_wdata;
   logic [7:0]  last_wstrb;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] word_at(input logic [63:0] aligned);
      logic [63:0] w;
      w = '0;
      for (int i = 0; i < 8; i++) w[8*i +: 8] = dmem_bytes[int'(aligned) + i];
      return w;
   endfunction

   task automatic set_word(input int idx, input logic [63:0] val);
      for (int i = 0; i < 8; i++) dmem_bytes[idx*8 + i] = val[8*i +: 8];
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input int stall, input int lat);
      int          n;
      int          off;
      int          cyc;
      logic        err;
      logic [63:0] e_rdata;
      logic [63:0] e_wdata;
      logic [63:0] e_addr;
      logic [7:0]  e_wstrb;
      n       = 1 << size;
      off     = int'(addr % 64'd8);
      err     = ((addr % 64'(n)) != 64'd0) || ((addr / 64'd8) >= 64'(DEPTH));
      e_addr  = addr & ~64'h7;
      e_rdata = '0;
      e_wdata = '0;
      e_wstrb = '0;
      if (!err) begin
         if (we) begin
            for (int i = 0; i < n; i++) begin
               e_wdata[8*(off+i) +: 8] = wdata[8*i +: 8];
               e_wstrb[off+i]          = 1'b1;
            end
         end else begin
            for (int i = 0; i < n; i++)
               e_rdata = e_rdata | (64'(dmem_bytes[int'(addr) + i]) << (8*i));
            if (!uns && n < 8 && e_rdata[8*n-1])
               e_rdata = e_rdata - (64'd1 << (8*n));
         end
      end

      chk("ready_idle", 64'(req_ready), 64'd1);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      tick();
      req_valid    = 1'b0;
      req_we       = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = {$urandom, $urandom};
      req_wdata    = {$urandom, $urandom};
      cyc = 1;

      if (err) begin
         chk("err_valid", 64'(rsp_valid), 64'd1);
         chk("err_flag", 64'(rsp_err), 64'd1);
         chk("err_rdata", rsp_rdata, 64'd0);
         chk("err_memreq", 64'(bus.mem_req_valid), 64'd0);
         chk("err_busy", 64'(req_ready), 64'd0);
         last_rdata = rsp_rdata;
         tick();
         chk("err_pulse", 64'(rsp_valid), 64'd0);
         chk("err_flag_clr", 64'(rsp_err), 64'd0);
         chk("err_memreq2", 64'(bus.mem_req_valid), 64'd0);
         chk("err_ready", 64'(req_ready), 64'd1);
         return;
      end

      for (int s = 0; s <= stall; s++) begin
         bus.mem_req_ready = (s == stall);
         chk("mreq_valid", 64'(bus.mem_req_valid), 64'd1);
         chk("mreq_we", 64'(bus.mem_we), 64'(we));
         chk("mreq_addr", bus.mem_addr, e_addr);
         chk("mreq_wstrb", 64'(bus.mem_wstrb), 64'(e_wstrb));
         if (we) chk("mreq_wdata", bus.mem_wdata, e_wdata);
         chk("busy_req", 64'(req_ready), 64'd0);
         chk("no_rsp_req", 64'(rsp_valid), 64'd0);
         if (s == stall) begin
            last_addr  = bus.mem_addr;
            last_wdata = bus.mem_wdata;
            last_wstrb = bus.mem_wstrb;
         end
         tick();
         cyc++;
      end
      bus.mem_req_ready = 1'b0;
      chk("mreq_drop", 64'(bus.mem_req_valid), 64'd0);

      for (int l = 0; l <= lat; l++) begin
         if (l == lat) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rdata     = word_at(e_addr);
         end
         chk("no_rsp_wait", 64'(rsp_valid), 64'd0);
         chk("busy_wait", 64'(req_ready), 64'd0);
         tick();
         cyc++;
      end
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rdata     = {$urandom, $urandom};
      if (we)
         for (int i = 0; i < n; i++) dmem_bytes[int'(addr) + i] = wdata[8*i +: 8];

      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_err", 64'(rsp_err), 64'd0);
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("latency", 64'(cyc), 64'(3 + stall + lat));
      last_rdata = rsp_rdata;
      tick();
      chk("rsp_pulse", 64'(rsp_valid), 64'd0);
      chk("rsp_rdata_clr", rsp_rdata, 64'd0);
      chk("ready_back", 64'(req_ready), 64'd1);
   endtask

   initial begin
      logic        r_we;
      logic [1:0]  r_size;
      logic        r_uns;
      logic [63:0] r_addr;
      int          r_n;
      int          r_idx;
      int          r_off;

      for (int i = 0; i < DEPTH*8; i++) dmem_bytes[i] = 8'($urandom);
      rst               = 1'b1;
      req_valid         = 1'b0;
      req_we            = 1'b0;
      req_size          = 2'b00;
      req_unsigned      = 1'b0;
      req_addr          = '0;
      req_wdata         = '0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rdata     = '0;
      tick();
      tick();
      chk("rst_ready", 64'(req_ready), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_rdata", rsp_rdata, 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      chk("rst_mreq", 64'(bus.mem_req_valid), 64'd0);
      chk("rst_mwe", 64'(bus.mem_we), 64'd0);
      chk("rst_maddr", bus.mem_addr, 64'd0);
      chk("rst_mwdata", bus.mem_wdata, 64'd0);
      chk("rst_mwstrb", 64'(bus.mem_wstrb), 64'd0);
      rst = 1'b0;
      tick();

      set_word(0, 64'hDEADBEEF_DEADBEEF);
      run_txn(1'b0, 2'b11, 1'b0, 64'h0, 64'h0, 0, 0);
      chk("ld_const", last_rdata, 64'hDEADBEEF_DEADBEEF);
      chk("ld_addr", last_addr, 64'h0);
      chk("ld_wstrb", 64'(last_wstrb), 64'h00);

      set_word(0, 64'h01234567_89ABCDEF);
      run_txn(1'b0, 2'b00, 1'b0, 64'h1, 64'h0, 0, 0);
      chk("lb_const", last_rdata, 64'hFFFFFFFF_FFFFFFCD);
      run_txn(1'b0, 2'b00, 1'b1, 64'h1, 64'h0, 1, 2);
      chk("lbu_const", last_rdata, 64'h00000000_000000CD);
      run_txn(1'b0, 2'b10, 1'b0, 64'h4, 64'h0, 0, 1);
      chk("lw_const", last_rdata, 64'h00000000_01234567);
      run_txn(1'b0, 2'b01, 1'b0, 64'h2, 64'h0, 2, 0);
      chk("lh_const", last_rdata, 64'hFFFFFFFF_FFFF89AB);

      run_txn(1'b1, 2'b01, 1'b0, 64'h6, 64'hFFFFFFFF_FFFFBEEF, 0, 0);
      chk("sh_addr", last_addr, 64'h0);
      chk("sh_wstrb", 64'(last_wstrb), 64'hC0);
      chk("sh_wdata", last_wdata, 64'hBEEF0000_00000000);
      chk("sh_rdata", last_rdata, 64'h0);

      run_txn(1'b0, 2'b10, 1'b0, 64'h2, 64'h0, 0, 0);
      chk("mis_rdata", last_rdata, 64'h0);
      run_txn(1'b0, 2'b11, 1'b0, 64'h2000, 64'h0, 0, 0);
      chk("oor_rdata", last_rdata, 64'h0);

      run_txn(1'b1, 2'b11, 1'b0, 64'h8, 64'hDEADBEEF_DEADBEF0, 3, 0);
      chk("sd_addr", last_addr, 64'h8);
      chk("sd_wstrb", 64'(last_wstrb), 64'hFF);
      chk("sd_wdata", last_wdata, 64'hDEADBEEF_DEADBEF0);

      // Reset arrives while the load sits in WAIT; the late ack must be dropped.
      req_valid    = 1'b1;
      req_we       = 1'b0;
      req_size     = 2'b11;
      req_unsigned = 1'b0;
      req_addr     = 64'h10;
      tick();
      req_valid         = 1'b0;
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_req_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rdata     = 64'h1111_2222_3333_4444;
      chk("rw_ready", 64'(req_ready), 64'd1);
      chk("rw_mreq", 64'(bus.mem_req_valid), 64'd0);
      chk("rw_maddr", bus.mem_addr, 64'd0);
      chk("rw_rsp_valid", 64'(rsp_valid), 64'd0);
      tick();
      bus.mem_rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rw_no_rsp", 64'(rsp_valid), 64'd0);
         chk("rw_rdata", rsp_rdata, 64'd0);
         chk("rw_ready2", 64'(req_ready), 64'd1);
         tick();
      end

      for (int t = 0; t < 200; t++) begin
         r_we   = 1'($urandom);
         r_size = 2'($urandom);
         r_uns  = 1'($urandom);
         r_n    = 1 << r_size;
         case ($urandom_range(0, 9))
            0: r_addr = 64'($urandom_range(DEPTH, DEPTH + 64)) * 64'd8;
            1: r_addr = 64'($urandom_range(0, 127));
            default: begin
               r_idx  = (t % 3 == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 15));
               r_off  = int'($urandom_range(0, 7)) & ~(r_n - 1);
               r_addr = 64'(r_idx * 8 + r_off);
            end
         endcase
         run_txn(r_we, r_size, r_uns, r_addr, {$urandom, $urandom},
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
Load/store initiator that drives the 64-bit data memory on behalf of the RV64I core. It accepts one load or store request at a time with a byte/half/word/double size. It converts the request into an 8-byte-aligned memory transaction with byte strobes and waits for the memory acknowledge. It then returns sign- or zero-extended load data, or a store completion, to the core.

Parameters:
DMEM_DEPTH, 1024, number of 64-bit words in data memory; word index = addr>>3
XLEN, 64, data width, fixed at 64

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  core request valid
req_ready  output  1  block can accept a request (IDLE only)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 double
req_unsigned  input  1  zero-extend load (LBU/LHU/LWU); ignored for stores and for size 11
req_addr  input  64  byte address
req_wdata  input  64  store data, right-justified
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  64  extended load data; 0 for stores and errors
rsp_err  output  1  misaligned or out-of-range; qualified by rsp_valid
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_we  output  1  memory write enable
mem_addr  output  64  8-byte-aligned address ({req_addr[63:3],3'b000})
mem_wdata  output  64  lane-shifted store data
mem_wstrb  output  8  byte strobes; 0 for loads
mem_rsp_valid  input  1  memory ack / read data valid
mem_rdata  input  64  memory read word

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE. All outputs are 0 except req_ready=1. Any in-flight transaction is abandoned.
- FSM states are IDLE, REQ, WAIT and RESP.
- IDLE: req_ready=1. On req_valid & req_ready, capture all req_* fields.
  - Misaligned (addr[0]!=0 for half, addr[1:0]!=0 for word, addr[2:0]!=0 for double) -> RESP with err=1.
  - Out of range (addr>>3 >= DMEM_DEPTH) -> RESP with err=1.
  - Otherwise -> REQ.
  - Errored requests never assert mem_req_valid.
- REQ: mem_req_valid=1. mem_we, mem_addr, mem_wdata and mem_wstrb are registered and held stable until mem_req_ready. On mem_req_valid & mem_req_ready -> WAIT, and mem_req_valid drops the next cycle.
- WAIT: wait for mem_rsp_valid for both loads and stores. When seen, register the extended data -> RESP. Any mem_rsp_valid outside WAIT is ignored.
- RESP: rsp_valid=1 for exactly one cycle, with rsp_rdata/rsp_err -> IDLE. rsp_rdata and rsp_err return to 0 in IDLE.
- Lane rules, with off = addr[2:0]:
  - mem_wdata = req_wdata << (8*off), with the unused upper bytes of req_wdata masked to 0.
  - mem_wstrb = {1,3,15,255}[size] << off.
  - Load raw value = mem_rdata >> (8*off), truncated to the size.
  - Sign-extend from bit 7/15/31 unless req_unsigned.
- Latency: accept at cycle 0. With mem_req_ready=1 at cycle 1 and mem_rsp_valid=1 at cycle 2, rsp_valid is at cycle 3. An error response appears at cycle 1.
- req_ready=0 outside IDLE, so there is never more than one outstanding transaction.

Test Plan:
- Load double: mem word 0 = DEADBEEF_DEADBEEF, load size 11 at addr 0x0 -> mem_addr=0, wstrb=0x00; rsp_rdata=DEADBEEF_DEADBEEF, err=0, rsp_valid at cycle 3.
- Byte extension: mem_rdata=0123456789ABCDEF.
  - LB at 0x1 -> FFFFFFFF_FFFFFFCD.
  - LBU at 0x1 -> 00000000_000000CD.
  - LW at 0x4 -> 00000000_01234567.
  - LH at 0x2 -> FFFFFFFF_FFFF89AB.
- Store half at 0x6, wdata=0x...FFFF_BEEF -> mem_addr=0, mem_we=1, wstrb=0xC0, mem_wdata=BEEF0000_00000000. After ack: rsp_valid=1, rdata=0.
- Misaligned LW at 0x2, and a load at addr 0x2000 with DEPTH=1024 -> rsp_valid at cycle 1 with err=1, rdata=0. mem_req_valid never asserts.
- Backpressure: SD at 0x8 with wdata=DEADBEEF_DEADBEF0, mem_req_ready low for 3 cycles -> mem_req_valid and all mem_* fields stable during the stall; after accept, mem_addr=0x8, wstrb=0xFF; req_ready=0 throughout.
- Reset in WAIT: assert rst for 1 cycle, then drive a late mem_rsp_valid -> outputs reset, req_ready=1, and no rsp_valid is produced.
